// File: rtl/spi_pkg.sv
// Shared register map, control-byte layout and FSM encoding for the SPI byte sequencer.
// Both helper functions build the bytes written to the SPI master.
package spi_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_TX   = 2'd1;
  localparam logic [1:0] ADDR_RX   = 2'd2;
  localparam logic [1:0] ADDR_SS   = 2'd3;

  localparam int CPOL_BIT  = 0;
  localparam int CPHA_BIT  = 1;
  localparam int CPRE_LSB  = 2;
  localparam int START_BIT = 6;
  localparam int END_BIT   = 7;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CFG     = 4'd1,
    ST_SS_ON   = 4'd2,
    ST_WAIT_IN = 4'd3,
    ST_WR_TX   = 4'd4,
    ST_START   = 4'd5,
    ST_UNSTART = 4'd6,
    ST_POLL_LO = 4'd7,
    ST_POLL_HI = 4'd8,
    ST_RD_RX   = 4'd9,
    ST_PUSH    = 4'd10,
    ST_SS_OFF  = 4'd11
  } seq_state_e;

  function automatic logic [7:0] ctrl_word(input logic [3:0] cpre, input logic cpha,
                                           input logic cpol, input logic start);
    logic [7:0] w;
    w                   = 8'h00;
    w[CPOL_BIT]         = cpol;
    w[CPHA_BIT]         = cpha;
    w[CPRE_LSB +: 4]    = cpre;
    w[START_BIT]        = start;
    return w;
  endfunction

  // Slave selects are active-low one-hot.
  function automatic logic [7:0] ss_word(input logic [2:0] slave);
    return ~(8'h01 << slave);
  endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Poll-phase watchdog: clearable, enable-gated counter that flags when the
// configured number of cycles has been spent in the current poll phase.
module spi_seq_timer #(
  parameter int TO_W  = 13,
  parameter int LIMIT = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + TO_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/spi_byte_sequencer.sv
// Turns a valid/ready byte stream into SPI-master register transactions and
// returns each received byte on a valid/ready output stream.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_W        = 13
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CfgCPol,
  input  logic       CfgCPha,
  input  logic [3:0] CfgCPre,
  input  logic [2:0] CfgSlave,
  input  logic       In_Valid,
  input  logic [7:0] In_Data,
  input  logic       In_Last,
  output logic       In_Ready,
  output logic       Out_Valid,
  output logic [7:0] Out_Data,
  input  logic       Out_Ready,
  output logic [1:0] RegAddr,
  output logic       RegWr,
  output logic [7:0] RegDataWr,
  input  logic [7:0] RegDataRd,
  output logic       Busy,
  output logic       Error
);

  seq_state_e state_q;
  logic [7:0] ctrl_q;
  logic [2:0] slave_q;
  logic       last_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic [1:0] reg_addr_q;
  logic       reg_wr_q;
  logic [7:0] reg_wdata_q;
  logic       busy_q;
  logic       error_q;

  logic       end_s;
  logic       polling_s;
  logic       tmr_clr_s;
  logic       expired_s;
  logic [7:0] ctrl_start_s;

  // The watchdog restarts whenever a poll phase is (re)entered.
  always_comb begin
    end_s        = RegDataRd[END_BIT];
    polling_s    = (state_q == ST_POLL_LO) || (state_q == ST_POLL_HI);
    tmr_clr_s    = !polling_s || ((state_q == ST_POLL_LO) && !end_s);
    ctrl_start_s = ctrl_q;
    ctrl_start_s[START_BIT] = 1'b1;
  end

  spi_seq_timer #(
    .TO_W (TO_W),
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (Clk),
    .rst_i    (Rst),
    .clr_i    (tmr_clr_s),
    .en_i     (polling_s),
    .expired_o(expired_s)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= 8'h00;
      slave_q     <= 3'd0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      reg_addr_q  <= 2'd0;
      reg_wr_q    <= 1'b0;
      reg_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (In_Valid) begin
            state_q     <= ST_CFG;
            ctrl_q      <= ctrl_word(CfgCPre, CfgCPha, CfgCPol, 1'b0);
            slave_q     <= CfgSlave;
            busy_q      <= 1'b1;
            reg_wr_q    <= 1'b1;
            reg_addr_q  <= ADDR_CTRL;
            reg_wdata_q <= ctrl_word(CfgCPre, CfgCPha, CfgCPol, 1'b0);
          end
        end
        ST_CFG: begin
          state_q     <= ST_SS_ON;
          reg_wr_q    <= 1'b1;
          reg_addr_q  <= ADDR_SS;
          reg_wdata_q <= ss_word(slave_q);
        end
        ST_SS_ON: begin
          state_q    <= ST_WAIT_IN;
          in_ready_q <= 1'b1;
        end
        ST_WAIT_IN: begin
          if (In_Valid && in_ready_q) begin
            state_q     <= ST_WR_TX;
            in_ready_q  <= 1'b0;
            last_q      <= In_Last;
            reg_wr_q    <= 1'b1;
            reg_addr_q  <= ADDR_TX;
            reg_wdata_q <= In_Data;
          end
        end
        ST_WR_TX: begin
          state_q     <= ST_START;
          reg_wr_q    <= 1'b1;
          reg_addr_q  <= ADDR_CTRL;
          reg_wdata_q <= ctrl_start_s;
        end
        ST_START: begin
          state_q     <= ST_UNSTART;
          reg_wr_q    <= 1'b1;
          reg_addr_q  <= ADDR_CTRL;
          reg_wdata_q <= ctrl_q;
        end
        ST_UNSTART: begin
          state_q    <= ST_POLL_LO;
          reg_addr_q <= ADDR_CTRL;
        end
        // Waiting for EndTx to drop first rejects a flag left over from the previous byte.
        ST_POLL_LO: begin
          if (!end_s) begin
            state_q <= ST_POLL_HI;
          end else if (expired_s) begin
            state_q     <= ST_SS_OFF;
            error_q     <= 1'b1;
            reg_wr_q    <= 1'b1;
            reg_addr_q  <= ADDR_SS;
            reg_wdata_q <= 8'hFF;
          end
        end
        ST_POLL_HI: begin
          if (end_s) begin
            state_q    <= ST_RD_RX;
            reg_addr_q <= ADDR_RX;
          end else if (expired_s) begin
            state_q     <= ST_SS_OFF;
            error_q     <= 1'b1;
            reg_wr_q    <= 1'b1;
            reg_addr_q  <= ADDR_SS;
            reg_wdata_q <= 8'hFF;
          end
        end
        ST_RD_RX: begin
          state_q     <= ST_PUSH;
          out_data_q  <= RegDataRd;
          out_valid_q <= 1'b1;
        end
        ST_PUSH: begin
          if (Out_Ready) begin
            out_valid_q <= 1'b0;
            if (last_q) begin
              state_q     <= ST_SS_OFF;
              reg_wr_q    <= 1'b1;
              reg_addr_q  <= ADDR_SS;
              reg_wdata_q <= 8'hFF;
            end else begin
              state_q    <= ST_WAIT_IN;
              in_ready_q <= 1'b1;
            end
          end
        end
        ST_SS_OFF: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Out_Data  = out_data_q;
  assign RegAddr   = reg_addr_q;
  assign RegWr     = reg_wr_q;
  assign RegDataWr = reg_wdata_q;
  assign Busy      = busy_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Scoreboard bench: a behavioural SPI-master model answers the register bus, the
// stimulus side queues expected register writes and RX bytes, a monitor pops and compares.
module tb_spi_byte_sequencer;
  import spi_pkg::*;

  localparam int SHIFT = 12;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       CfgCPol = 1'b0, CfgCPha = 1'b0;
  logic [3:0] CfgCPre = 4'd0;
  logic [2:0] CfgSlave = 3'd0;
  logic       In_Valid = 1'b0, In_Last = 1'b0;
  logic [7:0] In_Data = 8'h00;
  logic       In_Ready, Out_Valid;
  logic [7:0] Out_Data;
  logic       Out_Ready = 1'b1;
  logic [1:0] RegAddr;
  logic       RegWr;
  logic [7:0] RegDataWr, RegDataRd;
  logic       Busy, Error;

  always #5 Clk = ~Clk;

  spi_byte_sequencer #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
    .Clk(Clk), .Rst(Rst), .CfgCPol(CfgCPol), .CfgCPha(CfgCPha), .CfgCPre(CfgCPre),
    .CfgSlave(CfgSlave), .In_Valid(In_Valid), .In_Data(In_Data), .In_Last(In_Last),
    .In_Ready(In_Ready), .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Ready(Out_Ready),
    .RegAddr(RegAddr), .RegWr(RegWr), .RegDataWr(RegDataWr), .RegDataRd(RegDataRd),
    .Busy(Busy), .Error(Error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [9:0] exp_wr_q[$];
  logic [7:0] exp_out_q[$];

  // SPI master model: a start write launches a SHIFT-cycle transfer whose RX byte is TX ^ 8'h99.
  bit   stale_mode = 1'b0;
  bit   never_end  = 1'b0;
  logic [7:0] m_tx, m_rx;
  logic m_end, m_done;
  int   m_sh, m_stale;

  always_comb begin
    if (RegAddr == ADDR_RX) RegDataRd = m_rx;
    else if (RegAddr == ADDR_CTRL) RegDataRd = {m_end, 7'h00};
    else RegDataRd = 8'h00;
  end

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_tx <= 8'h00; m_rx <= 8'h00; m_end <= 1'b0; m_done <= 1'b0; m_sh <= 0; m_stale <= 0;
    end else begin
      if (m_stale > 0) begin
        m_stale <= m_stale - 1;
        if (m_stale == 1) m_end <= 1'b0;
      end
      if (m_sh > 0) begin
        m_sh <= m_sh - 1;
        if (m_sh == 1 && !never_end) begin
          m_end <= 1'b1; m_done <= 1'b1; m_rx <= m_tx ^ 8'h99;
        end
      end
      if (RegWr && RegAddr == ADDR_TX) m_tx <= RegDataWr;
      if (RegWr && RegAddr == ADDR_CTRL && RegDataWr[START_BIT]) begin
        m_sh <= SHIFT; m_done <= 1'b0;
        if (stale_mode) begin m_end <= 1'b1; m_stale <= 5; end
        else m_end <= 1'b0;
      end
    end
  end

  // Monitor: compares observed register writes and RX beats against the queued expectations.
  int cyc = 0, start_cyc = 0, err_cyc = 0, start_cnt = 0;
  logic [1:0] prev_addr = 2'd0;
  logic       prev_err  = 1'b0;
  always @(negedge Clk) begin
    logic [9:0] ew;
    logic [7:0] eo;
    cyc++;
    if (!Rst) begin
      if (RegWr) begin
        if (exp_wr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wr_unexpected: got addr %0d data %02h, expected no write", RegAddr, RegDataWr);
        end else begin
          ew = exp_wr_q.pop_front();
          check("wr_addr", RegAddr, ew[9:8]);
          check("wr_data", RegDataWr, ew[7:0]);
        end
        if (RegAddr == ADDR_CTRL && RegDataWr[START_BIT]) begin
          start_cyc = cyc; start_cnt++;
        end
      end
      if (Out_Valid && Out_Ready) begin
        if (exp_out_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL out_unexpected: got %02h, expected no beat", Out_Data);
        end else begin
          eo = exp_out_q.pop_front();
          check("out_data", Out_Data, eo);
        end
      end
      if (Out_Valid) check("in_ready_in_push", In_Ready, 1'b0);
      if (RegAddr == ADDR_RX && prev_addr != ADDR_RX) check("rx_after_endtx", m_done, 1'b1);
      if (Error && !prev_err) err_cyc = cyc;
    end
    prev_addr = RegAddr;
    prev_err  = Error;
  end

  // Out_Ready policy: 0 always ready, 1 random, 2 held low.
  int bp_mode = 0;
  initial begin
    forever begin
      @(posedge Clk); #1;
      case (bp_mode)
        0: Out_Ready = 1'b1;
        1: Out_Ready = ($urandom_range(0, 3) != 0);
        default: Out_Ready = 1'b0;
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last);
    bit done = 1'b0;
    In_Data = b; In_Last = last; In_Valid = 1'b1;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge Clk);
      if (In_Ready) begin @(posedge Clk); #1; done = 1'b1; end
    end
    In_Valid = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL in_accept: byte %02h not accepted, expected accept within 3000 cycles", b);
    end
  endtask

  task automatic send_frame(input logic [2:0] slave, input logic cpol, input logic cpha,
                            input logic [3:0] cpre, input logic [7:0] data[$], input bit expect_out);
    logic [7:0] cfg, ss;
    cfg = 8'(int'(cpre) * 4 + int'(cpha) * 2 + int'(cpol));
    ss  = 8'(255 - (1 << slave));
    exp_wr_q.push_back({ADDR_CTRL, cfg});
    exp_wr_q.push_back({ADDR_SS, ss});
    foreach (data[i]) begin
      exp_wr_q.push_back({ADDR_TX, data[i]});
      exp_wr_q.push_back({ADDR_CTRL, 8'(cfg + 8'd64)});
      exp_wr_q.push_back({ADDR_CTRL, cfg});
      if (expect_out) exp_out_q.push_back(data[i] ^ 8'h99);
    end
    exp_wr_q.push_back({ADDR_SS, 8'hFF});
    CfgSlave = slave; CfgCPol = cpol; CfgCPha = cpha; CfgCPre = cpre;
    foreach (data[i]) begin
      if (i > 0) repeat ($urandom_range(0, 3)) @(negedge Clk);
      send_byte(data[i], (i == data.size() - 1));
      CfgSlave = 3'($urandom); CfgCPol = 1'($urandom); CfgCPha = 1'($urandom); CfgCPre = 4'($urandom);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge Clk);
      if (!Busy && exp_wr_q.size() == 0 && exp_out_q.size() == 0) done = 1'b1;
    end
    check({tag, "_drained_idle"}, done, 1'b1);
    check({tag, "_busy"}, Busy, 1'b0);
  endtask

  task automatic bp_watch();
    bit seen = 1'b0;
    logic [7:0] held;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge Clk);
      if (Out_Valid) seen = 1'b1;
    end
    check("bp_valid_seen", seen, 1'b1);
    held = Out_Data;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      check("bp_data_stable", Out_Data, held);
      check("bp_in_ready_low", In_Ready, 1'b0);
      check("bp_valid_held", Out_Valid, 1'b1);
    end
    bp_mode = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, In_Ready, 1'b0);
    check({tag, "_out_valid"}, Out_Valid, 1'b0);
    check({tag, "_out_data"}, Out_Data, 8'h00);
    check({tag, "_reg_addr"}, RegAddr, 2'd0);
    check({tag, "_reg_wr"}, RegWr, 1'b0);
    check({tag, "_reg_wdata"}, RegDataWr, 8'h00);
    check({tag, "_busy"}, Busy, 1'b0);
    check({tag, "_error"}, Error, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    int sc;
    bit seen;
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    fr = '{8'hA5};
    send_frame(3'd2, 1'b0, 1'b0, 4'd4, fr, 1'b1);
    wait_idle("single");

    fr = '{8'h11, 8'h22, 8'h33};
    send_frame(3'd0, 1'b1, 1'b0, 4'd9, fr, 1'b1);
    wait_idle("three");

    fr = '{8'h5A, 8'hC3};
    bp_mode = 2;
    fork
      send_frame(3'd5, 1'b1, 1'b1, 4'd2, fr, 1'b1);
      bp_watch();
    join
    wait_idle("backpressure");

    stale_mode = 1'b1;
    fr = '{8'h0F, 8'hF0};
    send_frame(3'd6, 1'b0, 1'b1, 4'd15, fr, 1'b1);
    wait_idle("stale");
    stale_mode = 1'b0;

    bp_mode = 1;
    for (int f = 0; f < 6; f++) begin
      fr.delete();
      for (int b = 0; b < $urandom_range(1, 4); b++) fr.push_back(8'($urandom));
      send_frame(3'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), fr, 1'b1);
      wait_idle("random");
    end
    bp_mode = 0;
    check("error_clear_before_timeout", Error, 1'b0);

    never_end = 1'b1;
    fr = '{8'h42};
    send_frame(3'd7, 1'b1, 1'b0, 4'd1, fr, 1'b0);
    wait_idle("timeout");
    check("timeout_error", Error, 1'b1);
    check("timeout_latency", 32'(err_cyc - start_cyc), 32'd19);
    never_end = 1'b0;

    fr = '{8'h77};
    sc = start_cnt;
    send_frame(3'd1, 1'b0, 1'b1, 4'd3, fr, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge Clk);
      if (start_cnt != sc) seen = 1'b1;
    end
    check("rst_start_seen", seen, 1'b1);
    repeat (5) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_wr_q.delete();
    exp_out_q.delete();
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    fr = '{8'h3E, 8'hD1};
    send_frame(3'd4, 1'b1, 1'b1, 4'd6, fr, 1'b1);
    wait_idle("after_rst");
    check("after_rst_error", Error, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
